region_fill_writer: RTL and testbench
=====================================

# region_fill_writer

Write-side engine for the 320x240, 3-bit-per-pixel image RAM that the pixel fetch path reads. On a start pulse it latches a rectangle and a colour, clips the rectangle to the screen, and issues one RAM write per clock in row-major order. It uses the same linear address mapping as the read path (address = y*320 + x). It sits between game logic (redraw, erase, level edits) and the RAM write port.

## Interface
- SCREEN_W, 320, horizontal resolution in pixels
- SCREEN_H, 240, vertical resolution in pixels

- clock  in  1  single system clock; all logic on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- start  in  1  request; sampled only in IDLE
- x0  in  9  left column of rectangle
- y0  in  8  top row of rectangle
- width  in  9  rectangle width in pixels
- height  in  8  rectangle height in pixels
- color  in  3  fill colour
- busy  out  1  high while in FILL
- done  out  1  one-cycle completion pulse
- mem_address  out  17  RAM address, y*320 + x
- mem_data  out  3  RAM write data
- mem_wren  out  1  RAM write enable

## Operation
- States: IDLE, FILL, DONE.
- **IDLE, start=1:**
  - Latch x0, y0 and color.
  - Compute the clipped extent: We = min(width, SCREEN_W - x0), He = min(height, SCREEN_H - y0).
  - If x0 >= SCREEN_W, y0 >= SCREEN_H, We = 0 or He = 0, the request is empty: go to DONE with no writes.
  - Otherwise go to FILL with column counter cx = 0 and row counter cy = 0.
- **FILL:** each cycle write pixel (x0+cx, y0+cy).
  - cx increments every cycle.
  - At cx = We-1, cx wraps to 0 and cy increments.
  - On the write of (We-1, He-1), go to DONE.
- **DONE:** assert done for exactly one cycle, then return to IDLE.
- start is ignored in FILL and DONE; it is not queued.
- Input changes after the start cycle have no effect on an operation in progress.
- Address arithmetic:
  - mem_address = (y<<8) + (y<<6) + x, computed in 17 bits.
  - Maximum value is 76799; no overflow is possible after clipping.
- All outputs are registered.
- Reset values: state IDLE, busy 0, done 0, mem_wren 0, mem_address 0, mem_data 0.
- Reset asserted mid-FILL aborts the fill:
  - mem_wren drops asynchronously.
  - No done pulse is produced.
  - Writes already issued remain in RAM.

## Timing
- Start accepted at cycle N (state IDLE).
- Non-empty request of K = We*He pixels:
  - Writes occupy cycles N+1 .. N+K, with mem_wren=1 and busy=1 in every one of those cycles.
  - Write order is row-major.
  - done=1 at cycle N+K+1, with busy=0 and mem_wren=0.
  - State is IDLE at N+K+2; a new start is accepted from N+K+2.
- Empty request: done=1 at N+1, with no mem_wren cycles; IDLE at N+2.
- Throughput: one pixel per clock, with no bubbles between rows.
- mem_address and mem_data are valid in every cycle where mem_wren=1.
- mem_address and mem_data are don't-care but stable-holding when mem_wren=0.

## Test plan
- Basic 2x2 fill: x0=10, y0=5, w=2, h=2, color=5, start at N.
  - Required: writes at N+1..N+4 to addresses 1610, 1611, 1930, 1931, all with data 5.
  - Required: done pulse at N+5; busy high only during N+1..N+4.
- Edge clip: x0=318, y0=239, w=5, h=3, color=2.
  - Required: exactly 2 writes, to 76798 and 76799.
  - Required: done at N+3.
- Empty requests: w=0, and separately x0=320.
  - Required: done at N+1, mem_wren never asserted, busy never asserted.
- Start during fill: a 4x1 fill, with start pulsed again at N+2 with new x0 and color.
  - Required: the original 4 writes complete unchanged, there is only one done pulse, and no second fill occurs.
- Reset mid-fill: a 10x10 fill, with reset asserted at N+20.
  - Required: mem_wren=0 immediately and outputs at their reset values.
  - Required: no done pulse; a fresh start after reset runs normally.
- Full screen: x0=0, y0=0, w=320, h=240.
  - Required: 76800 consecutive writes with addresses 0..76799 in order.
  - Required: done at N+76801.

Source files
------------

// File: rtl/region_fill_writer.sv
// Rectangle fill engine for the 320x240x3 image RAM: clips a latched rectangle to the
// screen and writes it row-major, one pixel per clock, with address = y*320 + x.
module region_fill_writer #(
  parameter int SCREEN_W = 320,
  parameter int SCREEN_H = 240
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [8:0]  x0,
  input  logic [7:0]  y0,
  input  logic [8:0]  width,
  input  logic [7:0]  height,
  input  logic [2:0]  color,
  output logic        busy,
  output logic        done,
  output logic [16:0] mem_address,
  output logic [2:0]  mem_data,
  output logic        mem_wren
);

  localparam logic [9:0] SCREEN_W_V = 10'(SCREEN_W);
  localparam logic [8:0] SCREEN_H_V = 9'(SCREEN_H);

  typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

  state_t      state_reg, state_next;
  logic [8:0]  x0_reg, x0_next;
  logic [7:0]  y0_reg, y0_next;
  logic [8:0]  we_reg, we_next;
  logic [7:0]  he_reg, he_next;
  logic [8:0]  cx_reg, cx_next;
  logic [7:0]  cy_reg, cy_next;
  logic        busy_reg, busy_next;
  logic        done_reg, done_next;
  logic        wren_reg, wren_next;
  logic [16:0] addr_reg, addr_next;
  logic [2:0]  data_reg, data_next;

  logic [9:0]  room_w;
  logic [8:0]  room_h;
  logic [8:0]  ext_w;
  logic [7:0]  ext_h;
  logic        empty_req;
  logic        col_last;
  logic        row_last;

  // y*320 + x as y*256 + y*64 + x; never exceeds 76799 once clipped
  function automatic logic [16:0] pix_addr(input logic [7:0] y, input logic [8:0] x);
    return {1'b0, y, 8'd0} + {3'd0, y, 6'd0} + {8'd0, x};
  endfunction

  // Clipped extent of the request on the input side, used only at acceptance
  always_comb begin
    room_w    = ({1'b0, x0} < SCREEN_W_V) ? SCREEN_W_V - {1'b0, x0} : 10'd0;
    room_h    = ({1'b0, y0} < SCREEN_H_V) ? SCREEN_H_V - {1'b0, y0} : 9'd0;
    ext_w     = ({1'b0, width} < room_w) ? width : room_w[8:0];
    ext_h     = ({1'b0, height} < room_h) ? height : room_h[7:0];
    empty_req = (ext_w == 9'd0) || (ext_h == 8'd0);
  end

  assign col_last = (cx_reg == we_reg - 9'd1);
  assign row_last = (cy_reg == he_reg - 8'd1);

  always_comb begin
    state_next = state_reg;
    x0_next    = x0_reg;
    y0_next    = y0_reg;
    we_next    = we_reg;
    he_next    = he_reg;
    cx_next    = cx_reg;
    cy_next    = cy_reg;
    busy_next  = 1'b0;
    done_next  = 1'b0;
    wren_next  = 1'b0;
    addr_next  = addr_reg;
    data_next  = data_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          x0_next = x0;
          y0_next = y0;
          we_next = ext_w;
          he_next = ext_h;
          cx_next = 9'd0;
          cy_next = 8'd0;
          if (empty_req) begin
            state_next = DONE;
            done_next  = 1'b1;
          end else begin
            state_next = FILL;
            busy_next  = 1'b1;
            wren_next  = 1'b1;
            addr_next  = pix_addr(y0, x0);
            data_next  = color;
          end
        end
      end
      FILL: begin
        // The registered outputs currently carry pixel (cx, cy); line up the next one
        if (col_last && row_last) begin
          state_next = DONE;
          done_next  = 1'b1;
        end else begin
          busy_next = 1'b1;
          wren_next = 1'b1;
          if (col_last) begin
            cx_next = 9'd0;
            cy_next = cy_reg + 8'd1;
          end else begin
            cx_next = cx_reg + 9'd1;
          end
          addr_next = pix_addr(y0_reg + cy_next, x0_reg + cx_next);
        end
      end
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      x0_reg    <= '0;
      y0_reg    <= '0;
      we_reg    <= '0;
      he_reg    <= '0;
      cx_reg    <= '0;
      cy_reg    <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      wren_reg  <= 1'b0;
      addr_reg  <= '0;
      data_reg  <= '0;
    end else begin
      state_reg <= state_next;
      x0_reg    <= x0_next;
      y0_reg    <= y0_next;
      we_reg    <= we_next;
      he_reg    <= he_next;
      cx_reg    <= cx_next;
      cy_reg    <= cy_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
      wren_reg  <= wren_next;
      addr_reg  <= addr_next;
      data_reg  <= data_next;
    end
  end

  assign busy        = busy_reg;
  assign done        = done_reg;
  assign mem_wren    = wren_reg;
  assign mem_address = addr_reg;
  assign mem_data    = data_reg;

endmodule

// File: tb/tb_region_fill_writer.sv
// Self-checking bench for region_fill_writer: directed corner cases plus randomized
// rectangles, checked cycle by cycle against a clipped row-major pixel list.
module tb_region_fill_writer;

  logic        clock;
  logic        reset;
  logic        start;
  logic [8:0]  x0;
  logic [7:0]  y0;
  logic [8:0]  width;
  logic [7:0]  height;
  logic [2:0]  color;
  logic        busy;
  logic        done;
  logic [16:0] mem_address;
  logic [2:0]  mem_data;
  logic        mem_wren;

  int n_cmp = 0;
  int n_err = 0;

  region_fill_writer dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .x0          (x0),
    .y0          (y0),
    .width       (width),
    .height      (height),
    .color       (color),
    .busy        (busy),
    .done        (done),
    .mem_address (mem_address),
    .mem_data    (mem_data),
    .mem_wren    (mem_wren)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] all_outs();
    return {9'd0, busy, done, mem_wren, mem_data, mem_address};
  endfunction

  function automatic logic [31:0] ctl_outs();
    return {29'd0, busy, done, mem_wren};
  endfunction

  // Called at a negedge while idle: that cycle is N. Returns at the negedge of N+K+2,
  // after checking the design is idle again, so the next call tests back-to-back starts.
  // poke > 0 raises a stray start with fresh inputs during cycle N+poke.
  task automatic run_fill(input logic [8:0] rx, input logic [7:0] ry, input logic [8:0] rw,
                          input logic [7:0] rh, input logic [2:0] rc, input int poke);
    int q[$];
    int xe, ye, k;
    xe = int'(rx) + int'(rw);
    if (xe > 320) xe = 320;
    ye = int'(ry) + int'(rh);
    if (ye > 240) ye = 240;
    for (int y = int'(ry); y < ye; y++)
      for (int x = int'(rx); x < xe; x++)
        q.push_back(y * 320 + x);
    k = q.size();

    start = 1'b1; x0 = rx; y0 = ry; width = rw; height = rh; color = rc;
    for (int j = 1; j <= k + 1; j++) begin
      @(negedge clock);
      if (j <= k)
        check_val("write", all_outs(), {9'd0, 3'b101, rc, 17'(q[j-1])});
      else
        check_val("done", ctl_outs(), 32'b010);
      start  = (j == poke);
      x0     = 9'($urandom);
      y0     = 8'($urandom);
      width  = 9'($urandom);
      height = 8'($urandom);
      color  = 3'($urandom);
    end
    @(negedge clock);
    check_val("idle", ctl_outs(), 32'd0);
    start = 1'b0;
    $display("fill x0=%0d y0=%0d w=%0d h=%0d c=%0d poke=%0d -> %0d writes",
             rx, ry, rw, rh, rc, poke, k);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0;
    x0 = '0; y0 = '0; width = '0; height = '0; color = '0;
    repeat (2) @(negedge clock);
    check_val("reset", all_outs(), 32'd0);
    reset = 1'b0;
    @(negedge clock);

    run_fill(9'd10,  8'd5,   9'd2, 8'd2, 3'd5, 0);
    run_fill(9'd318, 8'd239, 9'd5, 8'd3, 3'd2, 0);
    run_fill(9'd10,  8'd5,   9'd0, 8'd4, 3'd1, 0);
    run_fill(9'd320, 8'd5,   9'd4, 8'd4, 3'd1, 0);
    run_fill(9'd20,  8'd30,  9'd4, 8'd1, 3'd6, 2);
    run_fill(9'd0,   8'd240, 9'd4, 8'd4, 3'd7, 0);

    // Reset in the middle of a 10x10 fill
    start = 1'b1; x0 = 9'd50; y0 = 8'd60; width = 9'd10; height = 8'd10; color = 3'd3;
    for (int j = 1; j <= 19; j++) begin
      @(negedge clock);
      check_val("rst_pre", all_outs(),
                {9'd0, 3'b101, 3'd3, 17'((60 + (j - 1) / 10) * 320 + 50 + (j - 1) % 10)});
      start = 1'b0;
    end
    @(negedge clock);
    reset = 1'b1;
    #1;
    check_val("rst_async", all_outs(), 32'd0);
    repeat (3) begin
      @(negedge clock);
      check_val("rst_hold", all_outs(), 32'd0);
    end
    reset = 1'b0;
    repeat (3) begin
      @(negedge clock);
      check_val("rst_after", ctl_outs(), 32'd0);
    end
    $display("reset mid-fill at N+20, fill aborted");
    run_fill(9'd100, 8'd100, 9'd3, 8'd2, 3'd4, 0);

    for (int t = 0; t < 25; t++) begin
      run_fill(9'($urandom_range(0, 330)), 8'($urandom_range(0, 250)),
               9'($urandom_range(0, 14)), 8'($urandom_range(0, 6)),
               3'($urandom), int'($urandom_range(0, 20)));
    end

    run_fill(9'd0, 8'd0, 9'd320, 8'd240, 3'd6, 0);
    repeat (3) begin
      @(negedge clock);
      check_val("tail", ctl_outs(), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
